// File: rtl/mux2_rr_arbiter.sv
// Round-robin arbiter for a shared 2-to-1 stream mux. Grants are held for a
// whole packet and are released early after MAX_BEATS beats.
module mux2_rr_arbiter #(
    parameter int unsigned DW        = 8,
    parameter int unsigned MAX_BEATS = 16,
    parameter int unsigned CW        = 5
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [DW-1:0] in0_data,
    input  logic          in0_valid,
    input  logic          in0_last,
    output logic          in0_ready,
    input  logic [DW-1:0] in1_data,
    input  logic          in1_valid,
    input  logic          in1_last,
    output logic          in1_ready,
    output logic [DW-1:0] out_data,
    output logic          out_valid,
    output logic          out_last,
    input  logic          out_ready,
    output logic          sel,
    output logic [1:0]    grant,
    output logic          forced
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        G0   = 2'd1,
        G1   = 2'd2
    } state_t;

    localparam logic [CW-1:0] LAST_CNT = CW'(MAX_BEATS - 1);

    state_t        state;
    state_t        state_n;
    logic          prio;
    logic          prio_n;
    logic [CW-1:0] beat_cnt;
    logic [CW-1:0] beat_cnt_n;

    logic          granted;
    logic          cur_valid;
    logic          cur_last;
    logic          cnt_at_max;
    logic          beat;
    logic          grant_end;

    // Ties go to the requester named by prio; a lone requester always wins.
    function automatic state_t arb(input logic v0, input logic v1, input logic p);
        state_t s;
        s = IDLE;
        if (v0 && v1) begin
            s = p ? G1 : G0;
        end else if (v0) begin
            s = G0;
        end else if (v1) begin
            s = G1;
        end
        return s;
    endfunction

    // Stream decode from the registered state; data path stays combinational.
    always_comb begin
        granted    = (state == G0) || (state == G1);
        cur_valid  = 1'b0;
        cur_last   = 1'b0;
        if (state == G0) begin
            cur_valid = in0_valid;
            cur_last  = in0_last;
        end else if (state == G1) begin
            cur_valid = in1_valid;
            cur_last  = in1_last;
        end
        cnt_at_max = (beat_cnt == LAST_CNT);
        beat       = cur_valid && out_ready;
        grant_end  = beat && (cur_last || cnt_at_max);
    end

    assign out_data  = sel ? in1_data : in0_data;
    assign out_valid = cur_valid;
    assign out_last  = granted && (cur_last || cnt_at_max);
    assign in0_ready = (state == G0) && out_ready;
    assign in1_ready = (state == G1) && out_ready;
    assign forced    = grant_end && !cur_last;

    // Next state: handover is evaluated on the same-cycle valids, no bubble.
    always_comb begin
        state_n    = state;
        prio_n     = prio;
        beat_cnt_n = beat_cnt;
        case (state)
            IDLE: begin
                state_n = arb(in0_valid, in1_valid, prio);
            end
            G0, G1: begin
                if (grant_end) begin
                    prio_n     = (state == G0);
                    beat_cnt_n = '0;
                    state_n    = arb(in0_valid, in1_valid, prio_n);
                end else if (beat) begin
                    beat_cnt_n = beat_cnt + CW'(1);
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            prio     <= 1'b0;
            beat_cnt <= '0;
            grant    <= 2'b00;
            sel      <= 1'b0;
        end else begin
            state    <= state_n;
            prio     <= prio_n;
            beat_cnt <= beat_cnt_n;
            grant    <= {state_n == G1, state_n == G0};
            sel      <= (state_n == G1);
        end
    end

endmodule

// File: tb/tb_mux2_rr_arbiter.sv
// Directed bench for mux2_rr_arbiter with default parameters (MAX_BEATS=16).
module tb_mux2_rr_arbiter;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [7:0] in0_data = 8'h00;
    logic       in0_valid = 1'b0;
    logic       in0_last = 1'b0;
    logic       in0_ready;
    logic [7:0] in1_data = 8'h00;
    logic       in1_valid = 1'b0;
    logic       in1_last = 1'b0;
    logic       in1_ready;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_last;
    logic       out_ready = 1'b0;
    logic       sel;
    logic [1:0] grant;
    logic       forced;

    int checks = 0;
    int errors = 0;

    mux2_rr_arbiter #(.DW(8), .MAX_BEATS(16), .CW(5)) dut (
        .clk(clk), .rst_n(rst_n),
        .in0_data(in0_data), .in0_valid(in0_valid), .in0_last(in0_last), .in0_ready(in0_ready),
        .in1_data(in1_data), .in1_valid(in1_valid), .in1_last(in1_last), .in1_ready(in1_ready),
        .out_data(out_data), .out_valid(out_valid), .out_last(out_last), .out_ready(out_ready),
        .sel(sel), .grant(grant), .forced(forced)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        in0_valid = 1'b0;
        in0_last  = 1'b0;
        in1_valid = 1'b0;
        in1_last  = 1'b0;
        out_ready = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        logic [1:0] exp_g [6];
        logic       pat   [6];
        exp_g = '{2'b01, 2'b01, 2'b10, 2'b10, 2'b01, 2'b01};
        pat   = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};

        // 1: reset values, then a lone 3-beat packet from in0
        #1;
        rst_n     = 1'b0;
        in0_data  = 8'h5A;
        in1_data  = 8'hC3;
        #2;
        chk("rst_grant", 32'(grant), 32'd0);
        chk("rst_sel", 32'(sel), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_ready0", 32'(in0_ready), 32'd0);
        chk("rst_ready1", 32'(in1_ready), 32'd0);
        chk("rst_forced", 32'(forced), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'h5A);
        do_reset();
        in0_valid = 1'b1;
        out_ready = 1'b1;
        #1;
        chk("t1_idle_grant", 32'(grant), 32'd0);
        chk("t1_idle_ready0", 32'(in0_ready), 32'd0);
        tick();
        for (int i = 0; i < 3; i++) begin
            in0_data = 8'hA0 + 8'(i);
            in0_last = (i == 2);
            #1;
            chk("t1_grant", 32'(grant), 32'd1);
            chk("t1_sel", 32'(sel), 32'd0);
            chk("t1_ready0", 32'(in0_ready), 32'd1);
            chk("t1_out_valid", 32'(out_valid), 32'd1);
            chk("t1_out_data", 32'(out_data), 32'(8'hA0 + 8'(i)));
            chk("t1_out_last", 32'(out_last), 32'(i == 2));
            tick();
        end

        // 2: both valid, 2-beat packets alternate 0,0,1,1,0,0 with no bubble
        do_reset();
        in0_valid = 1'b1;
        in1_valid = 1'b1;
        in0_data  = 8'h11;
        in1_data  = 8'h22;
        out_ready = 1'b1;
        tick();
        for (int i = 0; i < 6; i++) begin
            in0_last = pat[i];
            in1_last = pat[i];
            #1;
            chk("t2_grant", 32'(grant), 32'(exp_g[i]));
            chk("t2_sel", 32'(sel), 32'(exp_g[i] == 2'b10));
            chk("t2_out_data", 32'(out_data), (exp_g[i] == 2'b10) ? 32'h22 : 32'h11);
            chk("t2_out_last", 32'(out_last), 32'(pat[i]));
            tick();
        end

        // 3: in1 never asserts last; beat 16 is a forced release to in0
        do_reset();
        in1_valid = 1'b1;
        out_ready = 1'b1;
        tick();
        in0_valid = 1'b1;
        for (int i = 0; i < 16; i++) begin
            in1_data = 8'(i);
            #1;
            if (i >= 14) begin
                chk("t3_grant", 32'(grant), 32'd2);
                chk("t3_out_last", 32'(out_last), 32'(i == 15));
                chk("t3_forced", 32'(forced), 32'(i == 15));
            end
            tick();
        end
        #1;
        chk("t3_handover_grant", 32'(grant), 32'd1);
        chk("t3_forced_clear", 32'(forced), 32'd0);

        // 4: out_ready 1010 during G1 freezes the beat count on ready=0
        do_reset();
        in1_valid = 1'b1;
        tick();
        in0_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            out_ready = ((i % 2) == 0);
            #1;
            chk("t4_ready1", 32'(in1_ready), 32'(out_ready));
            chk("t4_ready0", 32'(in0_ready), 32'd0);
            tick();
        end
        out_ready = 1'b1;
        for (int i = 0; i < 14; i++) begin
            #1;
            if (i >= 12) begin
                chk("t4_out_last", 32'(out_last), 32'(i == 13));
                chk("t4_ready0_run", 32'(in0_ready), 32'd0);
            end
            tick();
        end

        // 5: asynchronous reset between edges mid-G1, then prio back to 0
        do_reset();
        in1_valid = 1'b1;
        out_ready = 1'b1;
        tick();
        tick();
        #2;
        chk("t5_pre_grant", 32'(grant), 32'd2);
        rst_n = 1'b0;
        #1;
        chk("t5_grant", 32'(grant), 32'd0);
        chk("t5_sel", 32'(sel), 32'd0);
        chk("t5_ready0", 32'(in0_ready), 32'd0);
        chk("t5_ready1", 32'(in1_ready), 32'd0);
        tick();
        rst_n     = 1'b1;
        in0_valid = 1'b1;
        tick();
        chk("t5_prio0_grant", 32'(grant), 32'd1);

        // 6: granted in0 stalls 4 cycles; grant holds, in1 never sees ready
        do_reset();
        in0_valid = 1'b1;
        in1_valid = 1'b1;
        out_ready = 1'b1;
        tick();
        tick();
        in0_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("t6_grant", 32'(grant), 32'd1);
            chk("t6_ready1", 32'(in1_ready), 32'd0);
            chk("t6_out_valid", 32'(out_valid), 32'd0);
            tick();
        end
        in0_valid = 1'b1;
        in0_last  = 1'b1;
        #1;
        chk("t6_resume_last", 32'(out_last), 32'd1);
        tick();
        chk("t6_handover", 32'(grant), 32'd2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
